// File: rtl/inst_enc_pkg.sv
// inst_enc_pkg: RV32 opcode constants, NOP word, format enum and format decode.
// Shared by imm_packer and inst_encoder (no ports).
package inst_enc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_SHIFT,
    FMT_S,
    FMT_SB,
    FMT_U,
    FMT_UJ,
    FMT_BAD
  } fmt_e;

  function automatic fmt_e fmt_of(
    input logic [6:0] op,
    input logic [2:0] f3
  );
    logic sh;
    fmt_e f;
    sh = (f3 == 3'b001) || (f3 == 3'b101);
    f  = FMT_BAD;
    unique case (1'b1)
      op == OP_OP:                          f = FMT_R;
      op == OP_IMM && sh:                   f = FMT_SHIFT;
      op == OP_IMM && !sh:                  f = FMT_I;
      op == OP_LOAD || op == OP_JALR:       f = FMT_I;
      op == OP_STORE:                       f = FMT_S;
      op == OP_BRANCH:                      f = FMT_SB;
      op == OP_LUI || op == OP_AUIPC:       f = FMT_U;
      op == OP_JAL:                         f = FMT_UJ;
      default:                              f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_packer.sv
// imm_packer: combinational field scatter into a 32-bit RV32 word plus fault flag.
// In: opcode,funct3,funct7,rd,rs1,rs2,imm. Out: inst, err. Macro INST_ENCODER_RANGE_CHECK_EN adds imm checks.
module imm_packer
  import inst_enc_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  fmt_e fmt;
  logic range_err;

  assign fmt = fmt_of(opcode, funct3);

  always_comb begin
    inst = NOP;
    unique case (fmt)
      FMT_R:
        inst = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:
        inst = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_SHIFT:
        inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      FMT_S:
        inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_SB:
        inst = {imm[12], imm[10:5], rs2, rs1, funct3,
                imm[4:1], imm[11], opcode};
      FMT_U:
        inst = {imm[31:12], rd, opcode};
      FMT_UJ:
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default:
        inst = NOP;
    endcase
  end

`ifdef INST_ENCODER_RANGE_CHECK_EN
  always_comb begin
    range_err = 1'b0;
    unique case (fmt)
      FMT_I, FMT_S:
        range_err = imm[31:11] != {21{imm[11]}};
      FMT_SHIFT:
        range_err = |imm[31:5];
      FMT_SB:
        range_err = (imm[31:12] != {20{imm[12]}}) || imm[0];
      FMT_UJ:
        range_err = (imm[31:20] != {12{imm[20]}}) || imm[0];
      FMT_U:
        range_err = |imm[11:0];
      default:
        range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign err = (fmt == FMT_BAD) || range_err;

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: field bundles in, registered RV32 words + write address out.
// Ports: start/in_* valid-ready in, out_* valid-ready out, done, err_sticky. Macro INST_ENCODER_RANGE_CHECK_EN.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              done,
  output logic              err_sticky
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_inc;
  logic              out_last;
  logic [31:0]       enc_inst;
  logic              enc_err;
  logic              hs;
  logic              take;

  imm_packer u_pack (
    .opcode (in_opcode),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .inst   (enc_inst),
    .err    (enc_err)
  );

  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign hs       = out_valid && out_ready;
  assign take     = in_valid && in_ready;
  assign cnt_inc  = cnt + 1'b1;
  assign done     = state == S_DONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      out_inst   <= '0;
      out_addr   <= BASE;
      out_err    <= 1'b0;
      out_last   <= 1'b0;
      cnt        <= BASE;
      err_sticky <= 1'b0;
    end else if (start) begin
      // Start wins over a coincident handshake: word dropped, count reloads.
      state      <= S_RUN;
      out_valid  <= 1'b0;
      cnt        <= BASE;
      err_sticky <= 1'b0;
    end else begin
      if (hs) begin
        cnt <= cnt_inc;
        if (out_err) err_sticky <= 1'b1;
        if (out_last) state <= S_DONE;
      end
      if (take) begin
        out_valid <= 1'b1;
        out_inst  <= enc_inst;
        // Counter bumps on the same edge, so capture its next value.
        out_addr  <= hs ? cnt_inc : cnt;
        out_err   <= enc_err;
        out_last  <= in_last;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: scoreboard bench for inst_encoder (ADDR_W=2).
// Expected words queued at acceptance, compared at output handshake.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [1:0]  out_addr;
  logic        out_err;
  logic        done;
  logic        err_sticky;

  typedef struct {
    logic [31:0] inst;
    logic [1:0]  addr;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic [1:0] exp_addr = '0;
  int n_cmp = 0;
  int n_bad = 0;

`ifdef INST_ENCODER_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_opcode  (in_opcode),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .done       (done),
    .err_sticky (err_sticky)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_enc(
    input logic [6:0] op, input logic [2:0] f3,
    input logic [6:0] f7, input logic [4:0] rd,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [31:0] imm);
    logic [31:0] w;
    case (op)
      7'b0110011: w = {f7, rs2, rs1, f3, rd, op};
      7'b0010011:
        if (f3 == 3'd1 || f3 == 3'd5)
          w = {f7, imm[4:0], rs1, f3, rd, op};
        else
          w = {imm[11:0], rs1, f3, rd, op};
      7'b0000011, 7'b1100111: w = {imm[11:0], rs1, f3, rd, op};
      7'b0100011: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      7'b1100011: w = {imm[12], imm[10:5], rs2, rs1, f3,
                       imm[4:1], imm[11], op};
      7'b0110111, 7'b0010111: w = {imm[31:12], rd, op};
      7'b1101111: w = {imm[20], imm[10:1], imm[11],
                       imm[19:12], rd, op};
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_word", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("out_inst", out_inst, e.inst);
        check("out_addr", {30'd0, out_addr}, {30'd0, e.addr});
        check("out_err", {31'd0, out_err}, {31'd0, e.err});
      end
    end
  end

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last);
    in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_last = last; in_valid = 1'b1;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic last,
                      input logic [31:0] xi, input logic xe);
    int n;
    exp_t x;
    set_in(op, f3, f7, rd, rs1, rs2, imm, last);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      x.inst = xi; x.addr = exp_addr; x.err = xe;
      q.push_back(x);
      exp_addr = exp_addr + 2'd1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 32'd0);
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = '0;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] imm;
    logic [11:0] v;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_addr", {30'd0, out_addr}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);

    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    do_start();
    check("run_in_ready", {31'd0, in_ready}, 32'd1);

    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0,
         32'h0050_0093, 1'b0);
    send(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0,
         32'h0020_A423, 1'b0);
    send(7'h13, 3'd5, 7'h20, 5'd3, 5'd3, 5'd0, 32'd2, 1'b0,
         32'h4021_D193, 1'b0);
    send(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b0,
         32'hFE20_8EE3, 1'b0);
    send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0,
         32'h0080_00EF, 1'b0);
    send(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0,
         32'h1234_52B7, 1'b0);
    drain();
    check("no_err_sticky", {31'd0, err_sticky}, 32'd0);

    send(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0,
         32'h0000_0013, 1'b1);
    drain();
    check("bad_op_sticky", {31'd0, err_sticky}, 32'd1);

    do_start();
    check("start_clr_sticky", {31'd0, err_sticky}, 32'd0);
    w = ref_enc(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    send(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, w, RC);
    drain();
    check("odd_br_sticky", {31'd0, err_sticky}, {31'd0, RC});

    for (int i = 0; i < 8; i++) begin
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        f3 = 3'($urandom);
        f7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        w = ref_enc(7'h33, f3, f7, rd, rs1, rs2, 32'd0);
        send(7'h33, f3, f7, rd, rs1, rs2, 32'd0, 1'b0, w, 1'b0);
      end else begin
        f3 = 3'($urandom);
        if (f3 == 3'd1 || f3 == 3'd5) f3 = 3'd0;
        v = 12'($urandom);
        imm = {{20{v[11]}}, v};
        w = ref_enc(7'h13, f3, 7'd0, rd, rs1, 5'd0, imm);
        send(7'h13, f3, 7'd0, rd, rs1, 5'd0, imm, 1'b0, w, 1'b0);
      end
    end
    drain();

    out_ready = 1'b0;
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0,
         32'h0050_0093, 1'b0);
    set_in(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_inst", out_inst, 32'h0050_0093);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0,
         32'h0080_00EF, 1'b0);
    send(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0,
         32'h1234_52B7, 1'b0);
    drain();

    do_start();
    for (int i = 0; i < 5; i++) begin
      rd = 5'(i + 1);
      w = ref_enc(7'h13, 3'd0, 7'd0, rd, 5'd0, 5'd0, 32'(i));
      send(7'h13, 3'd0, 7'd0, rd, 5'd0, 5'd0, 32'(i), i == 4,
           w, 1'b0);
    end
    drain();
    check("done_high", {31'd0, done}, 32'd1);
    check("done_in_ready", {31'd0, in_ready}, 32'd0);

    do_start();
    check("restart_done", {31'd0, done}, 32'd0);
    out_ready = 1'b0;
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0,
         32'h0050_0093, 1'b0);
    check("held_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    q.delete();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_inst", out_inst, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
